keypad_code_display: RTL and testbench

//  Receive end of the keypad encoder's 5-bit code bus: {valid, bcd[3:0]}.

---
 rtl/keypad_code_display.sv | 135 +++++++++++++
 tb/tb_keypad_code_display.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/keypad_code_display.sv
// Keypad receive end: debounces {valid,bcd} presses into an NDIG-digit shift buffer and scans it onto an active-low 7-seg display.
// Latency: key_strobe DEBOUNCE+1 cycles after code_in[4] rises; no backpressure, one accept per press, no auto-repeat.
module keypad_code_display #(
   parameter int NDIG     = 4,
   parameter int DEBOUNCE = 4,
   parameter int SCAN_DIV = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [4:0]           code_in,
   input  logic                 clr,
   output logic [6:0]           seg,
   output logic [NDIG-1:0]      an,
   output logic [4*NDIG-1:0]    digits,
   output logic [3:0]           count,
   output logic                 key_strobe,
   output logic                 err
);

   localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
   localparam int SW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(NDIG);
   localparam logic [3:0] NDIG_C  = 4'(NDIG);
   localparam logic       INSTANT = (DEBOUNCE == 1);

   typedef enum logic [1:0] {IDLE, ARM, ACCEPT, HELD} state_t;

   state_t          state;
   logic [4:0]      code_q;
   logic [3:0]      bcd_cap;
   logic [CW-1:0]   stab_cnt;
   logic [SW-1:0]   scan_cnt;
   logic [IW-1:0]   scan_idx;
   logic            go_accept;
   logic            acc_ok;
   logic [3:0]      acc_bcd;

   function automatic logic [6:0] seg_dec(input logic [3:0] d);
      case (d)
         4'd0:    seg_dec = 7'h40;
         4'd1:    seg_dec = 7'h79;
         4'd2:    seg_dec = 7'h24;
         4'd3:    seg_dec = 7'h30;
         4'd4:    seg_dec = 7'h19;
         4'd5:    seg_dec = 7'h12;
         4'd6:    seg_dec = 7'h02;
         4'd7:    seg_dec = 7'h78;
         4'd8:    seg_dec = 7'h00;
         4'd9:    seg_dec = 7'h10;
         default: seg_dec = 7'h7F;
      endcase
   endfunction

   // The accept decision is shared by IDLE (DEBOUNCE==1) and ARM so both paths update the buffer identically.
   always_comb begin
      acc_bcd   = (state == IDLE) ? code_q[3:0] : bcd_cap;
      go_accept = 1'b0;
      if (state == IDLE)
         go_accept = code_q[4] && INSTANT;
      else if (state == ARM)
         go_accept = code_q[4] && (code_q[3:0] == bcd_cap) && (stab_cnt >= CW'(DEBOUNCE - 1));
      acc_ok = (acc_bcd <= 4'd9);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         code_q     <= '0;
         bcd_cap    <= '0;
         stab_cnt   <= '0;
         digits     <= '0;
         count      <= '0;
         key_strobe <= 1'b0;
         err        <= 1'b0;
      end else begin
         code_q     <= code_in;
         key_strobe <= 1'b0;
         err        <= 1'b0;
         case (state)
            IDLE:
               if (code_q[4]) begin
                  bcd_cap  <= code_q[3:0];
                  stab_cnt <= CW'(1);
                  state    <= go_accept ? ACCEPT : ARM;
               end
            ARM:
               if (!code_q[4] || (code_q[3:0] != bcd_cap))
                  state <= IDLE;
               else if (go_accept)
                  state <= ACCEPT;
               else
                  stab_cnt <= stab_cnt + 1'b1;
            ACCEPT:  state <= HELD;
            HELD:    if (!code_q[4]) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (go_accept) begin
            if (!acc_ok)
               err <= 1'b1;
            else if (!clr) begin
               digits     <= {digits[4*NDIG-5:0], acc_bcd};
               count      <= (count >= NDIG_C) ? NDIG_C : count + 4'd1;
               key_strobe <= 1'b1;
            end
         end
         // clr overrides a coincident accept; the FSM still moves on to HELD.
         if (clr) begin
            digits <= '0;
            count  <= '0;
         end
      end
   end

   // seg/an load only on the first cycle of each scan period so they never change mid-period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         scan_idx <= '0;
         an       <= ~NDIG'(1);
         seg      <= 7'h7F;
      end else begin
         if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IW'(NDIG - 1)) ? '0 : scan_idx + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         if (scan_cnt == '0) begin
            an  <= ~(NDIG'(1) << scan_idx);
            seg <= (4'(scan_idx) < count) ? seg_dec(digits[4*scan_idx +: 4]) : 7'h7F;
         end
      end
   end

endmodule

// File: tb/tb_keypad_code_display.sv
// Scoreboard bench for keypad_code_display: stimulus queues expected strobe/err events, a negedge monitor pops and compares.
module tb_keypad_code_display;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  code_in = '0;
   logic        clr = 1'b0;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [15:0] digits;
   logic [3:0]  count;
   logic        key_strobe;
   logic        err;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct {
      logic        is_err;
      logic [15:0] dig;
      logic [3:0]  cnt;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   keypad_code_display #(.NDIG(4), .DEBOUNCE(4), .SCAN_DIV(16)) dut (
      .clk(clk), .rst_n(rst_n), .code_in(code_in), .clr(clr),
      .seg(seg), .an(an), .digits(digits), .count(count),
      .key_strobe(key_strobe), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every strobe/err pulse must match the next queued expectation.
   always @(negedge clk) begin
      if (rst_n && (key_strobe || err)) begin
         if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_event: got strobe=%b err=%b expected no event", key_strobe, err);
         end else begin
            mon_e = sb.pop_front();
            check("event_kind", {30'b0, err, key_strobe}, {30'b0, mon_e.is_err, !mon_e.is_err});
            check("event_state", {12'b0, count, digits}, {12'b0, mon_e.cnt, mon_e.dig});
         end
      end
   end

   task automatic expect_ev(input logic is_err, input logic [15:0] d, input logic [3:0] c);
      exp_t e;
      e.is_err = is_err;
      e.dig    = d;
      e.cnt    = c;
      sb.push_back(e);
   endtask

   // Drive a press at a negedge; lat = negedges until first strobe/err within the hold window, -1 if none.
   task automatic press(input logic [3:0] b, input int hold, input int idle, output int lat);
      code_in = {1'b1, b};
      lat = -1;
      for (int i = 1; i <= hold; i++) begin
         @(negedge clk);
         if (lat < 0 && (key_strobe || err)) lat = i;
      end
      code_in = '0;
      repeat (idle) @(negedge clk);
   endtask

   task automatic scan_check(input string name, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
      logic [6:0] ex [4];
      logic       seen [4];
      logic       bad  [4];
      logic       bad_an;
      ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
      bad_an = 1'b0;
      for (int i = 0; i < 4; i++) begin seen[i] = 1'b0; bad[i] = 1'b0; end
      repeat (32) @(negedge clk);
      for (int c = 0; c < 68; c++) begin
         @(negedge clk);
         case (an)
            4'b1110: begin seen[0] = 1'b1; if (seg !== ex[0]) bad[0] = 1'b1; end
            4'b1101: begin seen[1] = 1'b1; if (seg !== ex[1]) bad[1] = 1'b1; end
            4'b1011: begin seen[2] = 1'b1; if (seg !== ex[2]) bad[2] = 1'b1; end
            4'b0111: begin seen[3] = 1'b1; if (seg !== ex[3]) bad[3] = 1'b1; end
            default: bad_an = 1'b1;
         endcase
      end
      check({name, "_an_onehot"}, {31'b0, bad_an}, 32'd0);
      for (int i = 0; i < 4; i++)
         check($sformatf("%s_idx%0d", name, i), {30'b0, seen[i], bad[i]}, 32'b10);
   endtask

   initial begin
      int lat;
      int n;
      logic [3:0] an_prev;
      logic [3:0] an_cur;

      // T1 reset
      repeat (3) @(negedge clk);
      check("rst_seg", {25'b0, seg}, 32'h7F);
      check("rst_an", {28'b0, an}, 32'hE);
      check("rst_cnt_dig", {12'b0, count, digits}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_pulses", {30'b0, key_strobe, err}, 32'h0);

      // T2 sequence 0,1,9,7
      expect_ev(1'b0, 16'h0000, 4'd1); press(4'd0, 10, 5, lat); check("lat_0", lat, 5);
      expect_ev(1'b0, 16'h0001, 4'd2); press(4'd1, 10, 5, lat); check("lat_1", lat, 5);
      expect_ev(1'b0, 16'h0019, 4'd3); press(4'd9, 10, 5, lat); check("lat_9", lat, 5);
      expect_ev(1'b0, 16'h0197, 4'd4); press(4'd7, 10, 5, lat); check("lat_7", lat, 5);
      check("t2_state", {12'b0, count, digits}, {12'b0, 4'd4, 16'h0197});
      scan_check("t2_scan", 7'h78, 7'h10, 7'h79, 7'h40);

      // T3 overflow
      expect_ev(1'b0, 16'h1973, 4'd4); press(4'd3, 10, 5, lat); check("lat_3", lat, 5);
      check("t3_state", {12'b0, count, digits}, {12'b0, 4'd4, 16'h1973});

      // T4 glitch then invalid code
      press(4'd5, 2, 10, lat);
      check("glitch_no_pulse", lat, -1);
      check("glitch_state", {12'b0, count, digits}, {12'b0, 4'd4, 16'h1973});
      expect_ev(1'b1, 16'h1973, 4'd4); press(4'hA, 10, 5, lat); check("lat_err", lat, 5);
      check("err_state", {12'b0, count, digits}, {12'b0, 4'd4, 16'h1973});

      // T5 clr coincident with accept of 5
      code_in = 5'h15;
      repeat (4) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_accept", {11'b0, key_strobe, count, digits}, 32'h0);
      repeat (15) @(negedge clk);
      check("clr_held", {12'b0, count, digits}, 32'h0);
      code_in = '0;
      repeat (5) @(negedge clk);

      // T6 scan with count=2, then reset mid-period
      expect_ev(1'b0, 16'h0002, 4'd1); press(4'd2, 10, 5, lat); check("lat_2", lat, 5);
      expect_ev(1'b0, 16'h0028, 4'd2); press(4'd8, 10, 5, lat); check("lat_8", lat, 5);
      scan_check("t6_scan", 7'h00, 7'h24, 7'h7F, 7'h7F);

      an_prev = an;
      n = 0;
      while (an === an_prev && n < 40) begin @(negedge clk); n++; end
      an_cur = an;
      n = 0;
      while (an === an_cur && n < 40) begin @(negedge clk); n++; end
      check("scan_period", n, 16);

      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_seg_an", {21'b0, seg, an}, {21'b0, 7'h7F, 4'hE});
      check("midrst_state", {10'b0, key_strobe, err, count, digits}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
